// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one line-wide memory port
// between an I-cache (read only) and a D-cache (read and writeback).
// A granted transaction's address, data and opcode are latched on the grant
// edge and held on the memory port until the memory answers.
module mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  // D-cache side
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  // shared memory port
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              arb_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  state_e              state_q,      state_d;
  grant_e              last_grant_q, last_grant_d;
  logic                pmem_read_q,  pmem_read_d;
  logic                pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0]   addr_q,       addr_d;
  logic [LINE_W-1:0]   wdata_q,      wdata_d;

  logic                i_pending;
  logic                d_pending;
  logic                pick_d;

  assign i_pending = i_pmem_read;
  assign d_pending = d_pmem_read | d_pmem_write;

  // Next-state and grant decision; the winner's request is captured here.
  always_comb begin
    // NOTE: every variable gets a default up front so no path can leave one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    // NOTE: combinational logic uses blocking '=' so later statements see the
    // values computed earlier in the same block.
    pick_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_pending || d_pending) begin
          // On a tie the side that did not win last time goes first.
          pick_d = d_pending && (!i_pending || (last_grant_q == GRANT_I));
          if (pick_d) begin
            state_d      = SERVE_D;
            last_grant_d = GRANT_D;
            addr_d       = d_pmem_address;
            wdata_d      = d_pmem_wdata;
            // A simultaneous read and write from the D side resolves to write.
            pmem_write_d = d_pmem_write;
            pmem_read_d  = ~d_pmem_write;
          end else begin
            state_d      = SERVE_I;
            last_grant_d = GRANT_I;
            addr_d       = i_pmem_address;
            pmem_write_d = 1'b0;
            pmem_read_d  = 1'b1;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d      = DONE;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end
      end
      DONE: begin
        // One quiet cycle so the served requester can drop its request.
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
      end
    endcase
  end

  // State and registered memory-port outputs.
  // NOTE: reset is asynchronous, so it appears in the sensitivity list and
  // clears every flop immediately, even in the middle of a transaction;
  // sequential state uses non-blocking '<=' to avoid ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Read data is broadcast to both caches; only the completion pulse is steered.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state_q == SERVE_D) & pmem_resp;

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign arb_busy     = (state_q != IDLE);

  // The D cache must never ask for a fill and a writeback at once.
  d_read_write_exclusive: assert property (
    @(posedge clk) disable iff (rst) !(d_pmem_read && d_pmem_write)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a transaction-level
// reference model compared every cycle plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_pmem_read = 1'b0;
  logic [ADDR_W-1:0] i_pmem_address = '0;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read = 1'b0;
  logic              d_pmem_write = 1'b0;
  logic [ADDR_W-1:0] d_pmem_address = '0;
  logic [LINE_W-1:0] d_pmem_wdata = '0;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;
  logic              arb_busy;

  mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .arb_busy       (arb_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // owner: 0 = nobody, 1 = I cache, 2 = D cache. gap marks the quiet cycle
  // that follows every completion.
  int                m_owner  = 0;
  bit                m_gap    = 1'b0;
  bit                m_write  = 1'b0;
  bit                m_last_d = 1'b0;
  bit                want_i, want_d;
  logic [ADDR_W-1:0] m_addr   = '0;
  logic [LINE_W-1:0] m_wdata  = '0;
  int                cyc      = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = 0; m_gap = 1'b0; m_write = 1'b0; m_last_d = 1'b0;
      m_addr = '0; m_wdata = '0;
    end else begin
      cyc++;
      if (m_owner != 0) begin
        if (pmem_resp) begin
          m_owner = 0;
          m_gap   = 1'b1;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else begin
        want_i = i_pmem_read;
        want_d = d_pmem_read || d_pmem_write;
        if (want_i && want_d) m_owner = m_last_d ? 1 : 2;
        else if (want_d)      m_owner = 2;
        else if (want_i)      m_owner = 1;
        if (m_owner == 2) begin
          m_addr = d_pmem_address; m_wdata = d_pmem_wdata;
          m_write = d_pmem_write;  m_last_d = 1'b1;
        end else if (m_owner == 1) begin
          m_addr = i_pmem_address; m_write = 1'b0; m_last_d = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare and bookkeeping ----------------
  logic              prev_act = 1'b0;
  logic [ADDR_W-1:0] grant_log[$];
  int                grant_cyc[$];
  int                resp_cyc[$];
  int                i_resp_cnt = 0, d_resp_cnt = 0, resp_total = 0;
  int                rd_cyc_cnt = 0, wr_cyc_cnt = 0;

  always @(negedge clk) begin
    check("pmem_read",    pmem_read,    (m_owner != 0) && !m_write);
    check("pmem_write",   pmem_write,   (m_owner != 0) && m_write);
    check("pmem_address", pmem_address, m_addr);
    check("pmem_wdata",   pmem_wdata,   m_wdata);
    check("i_pmem_resp",  i_pmem_resp,  (m_owner == 1) && pmem_resp);
    check("d_pmem_resp",  d_pmem_resp,  (m_owner == 2) && pmem_resp);
    check("arb_busy",     arb_busy,     (m_owner != 0) || m_gap);
    check("i_pmem_rdata", i_pmem_rdata, pmem_rdata);
    check("d_pmem_rdata", d_pmem_rdata, pmem_rdata);
    if ((pmem_read || pmem_write) && !prev_act) begin
      grant_log.push_back(pmem_address);
      grant_cyc.push_back(cyc);
    end
    prev_act = pmem_read || pmem_write;
    if (i_pmem_resp) i_resp_cnt++;
    if (d_pmem_resp) d_resp_cnt++;
    if (i_pmem_resp || d_pmem_resp) begin
      resp_total++;
      resp_cyc.push_back(cyc);
    end
    if (pmem_read)  rd_cyc_cnt++;
    if (pmem_write) wr_cyc_cnt++;
  end

  // ---------------- memory responder ----------------
  // Answers an active request after mem_lat full cycles; can also inject a
  // spurious pulse when spur_req runs ahead of spur_done.
  int          mem_lat   = 2;
  int          mem_cnt   = 0;
  int          spur_req  = 0;
  int          spur_done = 0;
  logic [31:0] data_word;

  always begin
    @(posedge clk);
    #1;
    if (pmem_resp) begin
      pmem_resp = 1'b0;
    end else if (spur_req != spur_done) begin
      data_word  = $urandom;
      pmem_rdata = {8{data_word}};
      pmem_resp  = 1'b1;
      spur_done++;
    end else if (pmem_read || pmem_write) begin
      if (mem_cnt >= mem_lat) begin
        data_word  = $urandom;
        pmem_rdata = {8{data_word}};
        pmem_resp  = 1'b1;
        mem_cnt    = 0;
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_resp(input int target, input int budget, input string name);
    int k = 0;
    while (resp_total < target && k < budget) begin
      step();
      k++;
    end
    check({name, "_timeout"}, resp_total >= target, 1'b1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  logic [ADDR_W-1:0] exp_alt [6];
  logic [LINE_W-1:0] a5_line;
  int base_rd, base_wr, base_i, base_d, base_tot, g0, r0, c0;

  initial begin
    exp_alt = '{32'h200, 32'h100, 32'h200, 32'h100, 32'h200, 32'h100};
    a5_line = {32{8'hA5}};

    // Reset state.
    step(2);
    check("rst_pmem_read",    pmem_read,    1'b0);
    check("rst_pmem_address", pmem_address, '0);
    check("rst_arb_busy",     arb_busy,     1'b0);
    rst = 1'b0;
    step();

    // I-only read, memory answers after five busy cycles.
    mem_lat = 5;
    base_rd = rd_cyc_cnt; base_wr = wr_cyc_cnt; base_i = i_resp_cnt; base_d = d_resp_cnt;
    base_tot = resp_total; g0 = grant_log.size(); c0 = cyc;
    i_pmem_address = 32'h0000_1000;
    i_pmem_read    = 1'b1;
    wait_resp(base_tot + 1, 40, "iread");
    i_pmem_read = 1'b0;
    step(2);
    check("iread_read_cycles", rd_cyc_cnt - base_rd, 6);
    check("iread_i_resps",     i_resp_cnt - base_i, 1);
    check("iread_d_resps",     d_resp_cnt - base_d, 0);
    check("iread_addr",        grant_log[g0], 32'h0000_1000);
    check("iread_latency",     grant_cyc[g0] - c0, 1);

    // Simultaneous I and D after reset: D first, then I after DONE + IDLE.
    pulse_reset();
    mem_lat = 2;
    base_tot = resp_total; g0 = grant_log.size(); r0 = resp_cyc.size();
    i_pmem_address = 32'h100; d_pmem_address = 32'h200;
    i_pmem_read = 1'b1; d_pmem_read = 1'b1;
    wait_resp(base_tot + 1, 40, "tie_first");
    d_pmem_read = 1'b0;
    wait_resp(base_tot + 2, 40, "tie_second");
    i_pmem_read = 1'b0;
    step(2);
    check("tie_first_addr",  grant_log[g0],     32'h200);
    check("tie_second_addr", grant_log[g0 + 1], 32'h100);
    check("tie_no_bubble",   grant_cyc[g0 + 1] - resp_cyc[r0], 3);

    // D writeback of an A5 pattern.
    mem_lat = 3;
    base_rd = rd_cyc_cnt; base_wr = wr_cyc_cnt; base_d = d_resp_cnt;
    base_tot = resp_total; g0 = grant_log.size();
    d_pmem_address = 32'h300; d_pmem_wdata = a5_line; d_pmem_write = 1'b1;
    wait_resp(base_tot + 1, 40, "dwrite");
    d_pmem_write = 1'b0;
    step(2);
    check("dwrite_write_cycles", wr_cyc_cnt - base_wr, 4);
    check("dwrite_read_cycles",  rd_cyc_cnt - base_rd, 0);
    check("dwrite_d_resps",      d_resp_cnt - base_d, 1);
    check("dwrite_addr",         grant_log[g0], 32'h300);
    check("dwrite_wdata",        pmem_wdata, a5_line);

    // Both sides always requesting: six grants alternate D, I, D, I, D, I.
    pulse_reset();
    mem_lat = 1;
    base_tot = resp_total; g0 = grant_log.size();
    i_pmem_address = 32'h100; d_pmem_address = 32'h200; d_pmem_wdata = '0;
    i_pmem_read = 1'b1; d_pmem_read = 1'b1;
    wait_resp(base_tot + 6, 100, "alt");
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    step(2);
    for (int k = 0; k < 6; k++)
      check($sformatf("alt_grant%0d", k), grant_log[g0 + k], exp_alt[k]);

    // D address changes while its read is in service.
    mem_lat = 6;
    base_tot = resp_total; g0 = grant_log.size();
    d_pmem_address = 32'h500; d_pmem_read = 1'b1;
    step(3);
    d_pmem_address = 32'hDEAD_0000;
    step();
    check("hold_addr_mid", pmem_address, 32'h500);
    wait_resp(base_tot + 1, 40, "hold");
    d_pmem_read = 1'b0;
    step(2);
    check("hold_grant_addr", grant_log[g0], 32'h500);

    // Spurious memory response while idle.
    base_i = i_resp_cnt; base_d = d_resp_cnt;
    spur_req++;
    step(3);
    check("spur_i_resps", i_resp_cnt - base_i, 0);
    check("spur_d_resps", d_resp_cnt - base_d, 0);
    check("spur_busy",    arb_busy, 1'b0);

    // Reset while SERVE_D waits on a slow memory; late response ignored.
    mem_lat = 30;
    d_pmem_address = 32'h400; d_pmem_wdata = {8{32'h1234_5678}}; d_pmem_write = 1'b1;
    step(4);
    check("pre_rst_write", pmem_write, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("arst_pmem_write",   pmem_write,   1'b0);
    check("arst_pmem_read",    pmem_read,    1'b0);
    check("arst_pmem_address", pmem_address, '0);
    check("arst_pmem_wdata",   pmem_wdata,   '0);
    check("arst_arb_busy",     arb_busy,     1'b0);
    check("arst_d_resp",       d_pmem_resp,  1'b0);
    d_pmem_write = 1'b0;
    step();
    rst = 1'b0;
    base_d = d_resp_cnt; base_i = i_resp_cnt;
    step(2);
    spur_req++;
    step(3);
    check("late_d_resps", d_resp_cnt - base_d, 0);
    check("late_i_resps", i_resp_cnt - base_i, 0);
    check("late_busy",    arb_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LINE_W, default 256, cacheline width in bits.
REQ-002 Parameter: ADDR_W, default 32, physical address width.
REQ-003 Clocking: one clock, clk; reset rst is asynchronous and active-high.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 i_pmem_read  input  1  I-cache line fill request, held until i_pmem_resp.
REQ-007 i_pmem_address  input  ADDR_W  I-cache line address, line-aligned.
REQ-008 i_pmem_rdata  output  LINE_W  fill data to I-cache.
REQ-009 i_pmem_resp  output  1  one-cycle completion pulse to I-cache.
REQ-010 d_pmem_read  input  1  D-cache line fill request.
REQ-011 d_pmem_write  input  1  D-cache writeback request.
REQ-012 d_pmem_address  input  ADDR_W  D-cache line address.
REQ-013 d_pmem_wdata  input  LINE_W  D-cache writeback data.
REQ-014 d_pmem_rdata  output  LINE_W  fill data to D-cache.
REQ-015 d_pmem_resp  output  1  one-cycle completion pulse to D-cache.
REQ-016 pmem_read / pmem_write  output  1 each  request to the shared line memory port.
REQ-017 pmem_address  output  ADDR_W  latched address of the granted transaction.
REQ-018 pmem_wdata  output  LINE_W  latched writeback data.
REQ-019 pmem_rdata  input  LINE_W  line data from memory, valid with pmem_resp.
REQ-020 pmem_resp  input  1  memory completion pulse.
REQ-021 arb_busy  output  1  high in any state other than IDLE.

Function
REQ-022 FSM states SHALL be IDLE, SERVE_I, SERVE_D, DONE.
REQ-023 IDLE: no request -> stay; only I pending -> SERVE_I; only D pending (read or write) -> SERVE_D.
REQ-024 Both pending in IDLE: grant goes to the side not granted last (last_grant register), i.e. round-robin; last_grant resets to I so D wins the first tie.
REQ-025 On the grant edge: latch address, wdata and op (read/write) of the winner; update last_grant.
REQ-026 In SERVE_x: drive pmem_read or pmem_write (exactly one) plus latched address/wdata, held constant until pmem_resp.
REQ-027 Latency: request seen in IDLE at cycle N -> pmem_read/pmem_write high at cycle N+1.
REQ-028 pmem_resp in SERVE_x: pulse x_pmem_resp the same cycle (combinational), drop pmem_read/pmem_write next cycle, go to DONE.
REQ-029 DONE: one cycle, no grant, lets the requester deassert; then IDLE.
REQ-030 i_pmem_rdata and d_pmem_rdata SHALL both equal pmem_rdata at all times; only resp is steered.
REQ-031 x_pmem_resp SHALL never assert outside SERVE_x; never both resps in one cycle.
REQ-032 Requester drop mid-service: transaction still completes and its resp still pulses.
REQ-033 d_pmem_read and d_pmem_write both high: write wins; simulation assertion fires.
REQ-034 pmem_resp outside SERVE_I/SERVE_D: ignored, no state change, no resp forwarded.
REQ-035 Back-to-back: after DONE, a still-pending request of the other side is granted from IDLE with no extra bubble.

Reset
REQ-036 rst asserted (any state, including mid-transaction): immediately IDLE, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, i/d_pmem_resp=0, arb_busy=0, last_grant=I.
REQ-037 An in-flight memory transaction aborted by reset SHALL not be resumed; a pmem_resp arriving after reset is ignored per REQ-034.

Verification
REQ-038 I-only read 0x0000_1000, memory resp after 5 cycles -> pmem_read high cycles 1-6, pmem_address=0x1000, i_pmem_resp one pulse with pmem_resp, d_pmem_resp never high.
REQ-039 I read 0x100 and D read 0x200 same cycle after reset -> D granted first (pmem_address=0x200), then I (0x100) starting the cycle after DONE.
REQ-040 D write 0x300 with wdata 0xA5 pattern -> pmem_write high, pmem_wdata=pattern, pmem_read stays 0, d_pmem_resp pulses once.
REQ-041 Both sides continuously requesting for 6 transactions -> grants alternate D,I,D,I,D,I.
REQ-042 rst asserted while SERVE_D waits on memory -> all outputs zero asynchronously; late pmem_resp produces no resp pulse.
REQ-043 D requester changes d_pmem_address mid-service -> pmem_address stays at the latched value until completion.
